// File: rtl/mc_control_unit_if.sv
// ---------------------------------------------------------------------------
// mc_control_unit_if
//   Signal bundle between the multi-cycle RV32I control unit and the datapath.
//
//   Handshake: mem_ready is a level, sampled on the rising clock edge. A
//   memory access (FETCH, MEMREAD, MEMWRITE) completes in the cycle where
//   mem_ready = 1. Until then the control unit holds its state and its
//   strobes steady. There is no valid/ready back-pressure toward memory;
//   the strobes themselves are the request.
//
//   master : datapath side (drives instr/zero/mem_ready, receives controls)
//   slave  : control unit side
// ---------------------------------------------------------------------------
interface mc_control_unit_if;
    logic [31:0] instr;        // latched instruction
    logic        zero;         // ALU zero flag
    logic        mem_ready;    // memory access completes this cycle
    logic        ir_write;     // load IR and oldPC
    logic        pc_write;     // load PC
    logic        adr_src;      // 0 = PC, 1 = Result
    logic        mem_write;    // store strobe
    logic        reg_write;    // register-file write
    logic [1:0]  result_src;   // 00 ALUOut, 01 read data, 10 ALUResult
    logic [1:0]  alu_src_a;    // 00 PC, 01 oldPC, 10 rs1
    logic [1:0]  alu_src_b;    // 00 rs2, 01 imm, 10 const 4
    logic [1:0]  imm_src;      // 00 I, 01 S, 10 B, 11 J
    logic [2:0]  alu_control;  // 000 add, 001 sub, 010 and, 011 or, 101 slt
    logic        illegal;      // trap indicator
    logic [3:0]  state_dbg;    // current FSM state encoding

    modport master (
        output instr, zero, mem_ready,
        input  ir_write, pc_write, adr_src, mem_write, reg_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, illegal, state_dbg
    );

    modport slave (
        input  instr, zero, mem_ready,
        output ir_write, pc_write, adr_src, mem_write, reg_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, illegal, state_dbg
    );
endinterface

// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
//   Multi-cycle RV32I control unit (lw, sw, R-type, I-type ALU, beq, jal).
//   Moore main FSM plus combinational ALU and immediate decoders. Unknown
//   opcodes park the FSM in ILLEGAL until reset.
//
//   Ports:
//     clk    : rising-edge clock
//     reset  : asynchronous, active-low reset (state -> FETCH, strobes forced 0)
//     bus    : mc_control_unit_if.slave (instr/zero/mem_ready in, controls out)
//   Parameter:
//     WAIT_MEM : 1 = honour mem_ready, 0 = memory always ready
// ---------------------------------------------------------------------------
module mc_control_unit #(
    parameter bit WAIT_MEM = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    mc_control_unit_if.slave  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd15
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t      state, state_next;
    aluop_t      aluop;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        mem_rdy;
    logic        ir_write_raw, pc_update, branch, mem_write_raw, reg_write_raw;

    assign opcode   = bus.instr[6:0];
    assign funct3   = bus.instr[14:12];
    assign funct7b5 = bus.instr[30];
    assign mem_rdy  = WAIT_MEM ? bus.mem_ready : 1'b1;

    // Instruction bits this unit does not decode (register fields, rest of funct7).
    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next     = state;
        ir_write_raw   = 1'b0;
        pc_update      = 1'b0;
        branch         = 1'b0;
        mem_write_raw  = 1'b0;
        reg_write_raw  = 1'b0;
        bus.adr_src    = 1'b0;
        bus.result_src = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.illegal    = 1'b0;
        aluop          = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                // PC+4 goes straight from ALUResult into the PC.
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                ir_write_raw   = mem_rdy;
                pc_update      = mem_rdy;
                if (mem_rdy) state_next = S_DECODE;
            end
            S_DECODE: begin
                // oldPC + B-imm lands in ALUOut as the branch target.
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                state_next    = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                bus.adr_src = 1'b1;
                if (mem_rdy) state_next = S_MEMWB;
            end
            S_MEMWRITE: begin
                // Store strobe held for the whole wait, not just the last cycle.
                bus.adr_src   = 1'b1;
                mem_write_raw = 1'b1;
                if (mem_rdy) state_next = S_FETCH;
            end
            S_MEMWB: begin
                bus.result_src = 2'b01;
                reg_write_raw  = 1'b1;
                state_next     = S_FETCH;
            end
            S_EXECR: begin
                bus.alu_src_a = 2'b10;
                aluop         = ALUOP_FUNCT;
                state_next    = S_ALUWB;
            end
            S_EXECI: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                aluop         = ALUOP_FUNCT;
                state_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                state_next    = S_FETCH;
            end
            S_BEQ: begin
                bus.alu_src_a = 2'b10;
                aluop         = ALUOP_SUB;
                branch        = 1'b1;
                state_next    = S_FETCH;
            end
            S_JAL: begin
                // PC <- target (ALUOut), then ALUWB writes oldPC+4 to rd.
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                pc_update     = 1'b1;
                state_next    = S_ALUWB;
            end
            S_ILLEGAL: begin
                bus.illegal = 1'b1;
            end
            default: state_next = S_ILLEGAL;
        endcase
    end

    // Strobes are masked by reset so nothing fires while reset is low,
    // even though FETCH itself would raise ir_write on mem_ready.
    assign bus.ir_write  = reset & ir_write_raw;
    assign bus.pc_write  = reset & (pc_update | (branch & bus.zero));
    assign bus.mem_write = reset & mem_write_raw;
    assign bus.reg_write = reset & reg_write_raw;
    assign bus.state_dbg = state;

    always_comb begin
        bus.alu_control = 3'b000;
        case (aluop)
            ALUOP_SUB: bus.alu_control = 3'b001;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  bus.alu_control = (opcode[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  bus.alu_control = 3'b101;
                    3'b110:  bus.alu_control = 3'b011;
                    3'b111:  bus.alu_control = 3'b010;
                    default: bus.alu_control = 3'b000;
                endcase
            end
            default: bus.alu_control = 3'b000;
        endcase
    end

    always_comb begin
        bus.imm_src = 2'b00;
        case (opcode)
            OP_SW:   bus.imm_src = 2'b01;
            OP_BEQ:  bus.imm_src = 2'b10;
            OP_JAL:  bus.imm_src = 2'b11;
            default: bus.imm_src = 2'b00;
        endcase
    end

endmodule
